multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Sequencing FSM for the RV32I multicycle datapath: it steps each instruction through
//  FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//  Consumes the one-hot instruction-class lines that also feed control_decoder.
//  Drives the datapath's state-qualified write/request strobes and handshakes with
//  instruction and data memory.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles waiting on imem_ready/dmem_ready before FAULT (>=1)
//  CNT_W           32  width of performance counters
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      run enable; level-sensitive
//  r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type,
//  u_type_auipc, u_type_lui, uj_type   in 1 each   one-hot instruction class
//  branch_taken  in   1      branch comparison result (valid in EXECUTE)
//  imem_ready    in   1      instruction memory data valid
//  dmem_ready    in   1      data memory access complete
//  ir_write      out  1      latch instruction register
//  pc_write      out  1      commit next PC
//  reg_write     out  1      register file write enable
//  dmem_req      out  1      data memory request
//  dmem_we       out  1      data memory write (valid with dmem_req)
//  state         out  3      current state encoding
//  busy          out  1      state not IDLE and not FAULT
//  fault         out  1      sticky error flag
//  cycle_count   out  CNT_W  active-cycle counter (see CONFIGURATION)
//  instret       out  CNT_W  retired-instruction counter (see CONFIGURATION)
// BEHAVIOUR
//  - States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6.
//  - Reset: state=IDLE; class register, wait counter and perf counters=0.
//    All outputs are 0 while rst_n=0.
//  - Strobes are combinational from state, the latched class and the ready inputs.
//  - IDLE: start=1 -> FETCH.
//  - FETCH: ir_write = imem_ready; imem_ready -> DECODE.
//  - DECODE: latch the 9 class bits. Popcount!=1 -> FAULT; otherwise -> EXECUTE.
//  - EXECUTE (1 cycle):
//    - lw / s_type -> MEMORY.
//    - sb_type: pc_write=1 regardless of branch_taken (PC mux selects target);
//      then -> FETCH if start, else IDLE.
//    - All other classes -> WRITEBACK.
//  - MEMORY: dmem_req=1, dmem_we=latched s_type. On dmem_ready:
//    - store: pc_write=1, then -> FETCH/IDLE.
//    - load: -> WRITEBACK.
//  - WRITEBACK: reg_write=1, pc_write=1; then -> FETCH if start, else IDLE.
//  - Wait counter:
//    - Clears on entry to FETCH/MEMORY; increments each cycle the ready input is low.
//    - Reaching TIMEOUT_CYCLES without ready -> FAULT.
//    - Ready arriving in the same cycle the count hits the limit wins (no fault).
//  - FAULT: fault=1, all strobes 0; exits only via rst_n.
//  - start deasserted mid-instruction: the instruction completes, then IDLE.
//  - Latency with zero-wait memories: branch 3, r/i/u/jal/jalr 4, store 4, load 5 cycles.
//  - Async reset mid-instruction: immediate return to IDLE; no partial strobes after reset.
// CONFIGURATION
//  PERF_COUNTERS_EN defined:
//    - cycle_count +1 every cycle busy=1.
//    - instret +1 on every pc_write.
//    - Both wrap modulo 2^CNT_W; both clear on reset.
//  Not defined: cycle_count and instret are tied to 0; no counter flops are synthesised.
// TESTING
//  - r_type, start=1, both readies=1 -> states 1,2,3,5; reg_write and pc_write high
//    in cycle 4 only; back to FETCH.
//  - i_type_lw, dmem_ready low 3 cycles -> MEMORY held 4 cycles with dmem_req=1,
//    dmem_we=0; then WRITEBACK; 8 cycles total.
//  - s_type -> dmem_we=1 in MEMORY; pc_write on ready; reg_write never asserted.
//  - Two class bits set in DECODE (r_type+s_type) -> FAULT, fault=1;
//    start toggling has no effect; rst_n low -> IDLE.
//  - dmem_ready held low, TIMEOUT_CYCLES=4 -> FAULT after 4 MEMORY cycles;
//    ready on cycle 4 instead -> no fault.
//  - PERF_COUNTERS_EN, CNT_W=4: 5 back-to-back sb_type -> instret=5, cycle_count=15;
//    20 instrs -> instret wraps to 4.

Source files
------------

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the RV32I multicycle datapath (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Optional perf counters under PERF_COUNTERS_EN; memory waits bounded by TIMEOUT_CYCLES.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             r_type,
  input  logic             i_type_lw,
  input  logic             i_type_addi,
  input  logic             i_type_jalr,
  input  logic             s_type,
  input  logic             sb_type,
  input  logic             u_type_auipc,
  input  logic             u_type_lui,
  input  logic             uj_type,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [2:0]       state,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  localparam int CLS_LW = 1;
  localparam int CLS_S  = 4;
  localparam int CLS_SB = 5;

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [8:0]        class_in;
  logic [8:0]        class_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              ready_sel;
  logic              timeout;
  logic              class_ok;
  logic              after_retire;

  // branch_taken only steers the datapath PC mux; sequencing is identical either way.
  logic unused_branch;
  assign unused_branch = branch_taken;

  assign class_in = {uj_type, u_type_lui, u_type_auipc, sb_type, s_type,
                     i_type_jalr, i_type_addi, i_type_lw, r_type};
  assign class_ok = $onehot(class_in);

  assign waiting   = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign ready_sel = (state_q == S_FETCH) ? imem_ready : dmem_ready;
  // Ready in the same cycle as the last allowed wait beats the timeout.
  assign timeout   = waiting && !ready_sel && (wait_cnt == WAIT_LAST);

  assign after_retire = start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready)   state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        state_d = class_ok ? S_EXECUTE : S_FAULT;
      end
      S_EXECUTE: begin
        if (class_q[CLS_LW] || class_q[CLS_S]) state_d = S_MEMORY;
        else if (class_q[CLS_SB])              state_d = after_retire ? S_FETCH : S_IDLE;
        else                                   state_d = S_WRITEBACK;
      end
      S_MEMORY: begin
        if (dmem_ready) begin
          if (class_q[CLS_S]) state_d = after_retire ? S_FETCH : S_IDLE;
          else                state_d = S_WRITEBACK;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        state_d = after_retire ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_q <= '0;
    end else if (state_q == S_DECODE) begin
      class_q <= class_in;
    end
  end

  // Any state change clears the count, which covers entry into FETCH and MEMORY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if (waiting && !ready_sel) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    ir_write  = (state_q == S_FETCH) && imem_ready;
    reg_write = (state_q == S_WRITEBACK);
    dmem_req  = (state_q == S_MEMORY);
    dmem_we   = (state_q == S_MEMORY) && class_q[CLS_S];
    pc_write  = ((state_q == S_EXECUTE) && class_q[CLS_SB])
             || ((state_q == S_MEMORY) && class_q[CLS_S] && dmem_ready)
             || (state_q == S_WRITEBACK);
  end

  assign state = state_q;
  assign fault = (state_q == S_FAULT);
  assign busy  = (state_q != S_IDLE) && (state_q != S_FAULT);

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (busy)     cycle_q   <= cycle_q + 1'b1;
      if (pc_write) instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_count = cycle_q;
  assign instret     = instret_q;
`else
  assign cycle_count = '0;
  assign instret     = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench: per-instruction expected cycle traces are built from the class and
// injected stall counts, then replayed against the DUT cycle by cycle.
module tb_multicycle_controller;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int MOD = 1 << CW;

  typedef struct {
    logic          rst_n;
    logic          start;
    logic          imem_ready;
    logic          dmem_ready;
    logic          branch_taken;
    logic [8:0]    cls;
    logic [2:0]    st;
    logic          ir;
    logic          pc;
    logic          rw;
    logic          req;
    logic          we;
    logic          busy;
    logic          flt;
    logic [CW-1:0] cyc;
    logic [CW-1:0] ret;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [8:0] cls = '0;
  logic branch_taken = 1'b0;
  logic imem_ready = 1'b0;
  logic dmem_ready = 1'b0;
  logic ir_write, pc_write, reg_write, dmem_req, dmem_we, busy, fault;
  logic [2:0] state;
  logic [CW-1:0] cycle_count, instret;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .r_type(cls[0]), .i_type_lw(cls[1]), .i_type_addi(cls[2]), .i_type_jalr(cls[3]),
    .s_type(cls[4]), .sb_type(cls[5]), .u_type_auipc(cls[6]), .u_type_lui(cls[7]),
    .uj_type(cls[8]), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .state(state), .busy(busy), .fault(fault),
    .cycle_count(cycle_count), .instret(instret)
  );

  rec_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_cyc = 0;
  int   m_ret = 0;
  bit   m_idle = 1'b1;
  int   budget = -1;
  int   gen_len = 0;

  function automatic rec_t blank();
    rec_t r;
    r.rst_n = 1'b1;
    r.start = 1'($urandom);
    r.imem_ready = 1'($urandom);
    r.dmem_ready = 1'($urandom);
    r.branch_taken = 1'($urandom);
    r.cls = 9'($urandom);
    r.st = 3'd0; r.ir = 1'b0; r.pc = 1'b0; r.rw = 1'b0; r.req = 1'b0; r.we = 1'b0;
    r.busy = 1'b0; r.flt = 1'b0; r.cyc = '0; r.ret = '0;
    return r;
  endfunction

  function automatic logic [8:0] rand_cls();
    int k = $urandom_range(0, 19);
    logic [8:0] v;
    if (k < 18) begin
      v = 9'd1 << (k % 9);
    end else if (k == 18) begin
      v = '0;
    end else begin
      int a = $urandom_range(0, 8);
      int b = (a + $urandom_range(1, 8)) % 9;
      v = (9'd1 << a) | (9'd1 << b);
    end
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counters seen in a cycle reflect the activity of all earlier cycles.
  task automatic push_rec(input rec_t r);
    if (budget == 0) return;
    if (budget > 0) budget--;
    if (!r.rst_n) begin
      m_cyc = 0;
      m_ret = 0;
      r.cyc = '0;
      r.ret = '0;
    end else begin
      r.cyc = CW'(m_cyc);
      r.ret = CW'(m_ret);
      if (r.busy) m_cyc = (m_cyc + 1) % MOD;
      if (r.pc)   m_ret = (m_ret + 1) % MOD;
    end
    gen_len++;
    q.push_back(r);
  endtask

  task automatic do_reset();
    rec_t r;
    budget = -1;
    repeat (2) begin
      r = blank();
      r.rst_n = 1'b0;
      push_rec(r);
    end
    m_idle = 1'b1;
  endtask

  task automatic fault_tail();
    rec_t r;
    repeat ($urandom_range(3, 6)) begin
      r = blank();
      r.st = 3'd6;
      r.flt = 1'b1;
      push_rec(r);
    end
    do_reset();
  endtask

  task automatic stalled(input logic [2:0] st, input bit mem, input bit we);
    rec_t r = blank();
    r.st = st; r.busy = 1'b1; r.req = mem; r.we = we;
    if (mem) r.dmem_ready = 1'b0;
    else     r.imem_ready = 1'b0;
    push_rec(r);
  endtask

  task automatic gen_instr(input logic [8:0] c, input int fs, input int ms, input bit st_end);
    rec_t r;
    bit is_ld, is_st, is_br;
    if (m_idle) begin
      repeat ($urandom_range(0, 2)) begin
        r = blank(); r.start = 1'b0; push_rec(r);
      end
      r = blank(); r.start = 1'b1; push_rec(r);
    end
    m_idle = 1'b0;
    gen_len = 0;
    for (int k = 0; k < fs && k < TO; k++) stalled(3'd1, 1'b0, 1'b0);
    if (fs >= TO) begin fault_tail(); return; end
    r = blank(); r.st = 3'd1; r.busy = 1'b1; r.imem_ready = 1'b1; r.ir = 1'b1; push_rec(r);
    r = blank(); r.st = 3'd2; r.busy = 1'b1; r.cls = c; push_rec(r);
    if ($countones(c) != 1) begin fault_tail(); return; end
    is_ld = c[1]; is_st = c[4]; is_br = c[5];
    r = blank(); r.st = 3'd3; r.busy = 1'b1;
    if (is_br) begin
      r.pc = 1'b1; r.start = st_end; push_rec(r);
      m_idle = !st_end;
      return;
    end
    push_rec(r);
    if (is_ld || is_st) begin
      for (int k = 0; k < ms && k < TO; k++) stalled(3'd4, 1'b1, is_st);
      if (ms >= TO) begin fault_tail(); return; end
      r = blank(); r.st = 3'd4; r.busy = 1'b1; r.req = 1'b1; r.we = is_st; r.dmem_ready = 1'b1;
      if (is_st) begin
        r.pc = 1'b1; r.start = st_end; push_rec(r);
        m_idle = !st_end;
        return;
      end
      push_rec(r);
    end
    r = blank(); r.st = 3'd5; r.busy = 1'b1; r.rw = 1'b1; r.pc = 1'b1; r.start = st_end;
    push_rec(r);
    m_idle = !st_end;
  endtask

  function automatic int rand_stall();
    int k = $urandom_range(0, 9);
    if (k == 9) return TO;
    if (k >= 6) return $urandom_range(1, TO - 1);
    return 0;
  endfunction

  initial begin
    rec_t cur;
    logic [9:0] act_v, exp_v;
    logic [CW-1:0] exp_cyc, exp_ret;

    do_reset();
    gen_instr(9'h001, 0, 0, 1'b1); check("len_r_type", gen_len, 4);
    gen_instr(9'h002, 0, 3, 1'b1); check("len_lw_stall3", gen_len, 8);
    gen_instr(9'h010, 0, 0, 1'b0); check("len_store", gen_len, 4);
    gen_instr(9'h002, 0, 0, 1'b1); check("len_load", gen_len, 5);
    gen_instr(9'h020, 0, 0, 1'b0); check("len_branch", gen_len, 3);
    gen_instr(9'h010, 0, TO - 1, 1'b0);
    gen_instr(9'h010, 0, TO, 1'b1);
    gen_instr(9'h011, 0, 0, 1'b1);
    gen_instr(9'h008, TO, 0, 1'b1);

    m_idle = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) gen_instr(9'h020, 0, 0, (i < 4));
    check("model_sb5_cycles", m_cyc, 15);
    check("model_sb5_instret", m_ret, 5);
    for (int i = 0; i < 15; i++) gen_instr(9'h020, 0, 0, 1'b1);
    check("model_wrap_instret", m_ret, 4);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        budget = $urandom_range(1, 6);
        gen_instr(rand_cls(), rand_stall(), rand_stall(), 1'($urandom));
        do_reset();
      end else begin
        gen_instr(rand_cls(), rand_stall(), rand_stall(), ($urandom_range(0, 3) != 0));
      end
    end

    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk);
      #1;
      rst_n = cur.rst_n; start = cur.start; cls = cur.cls; branch_taken = cur.branch_taken;
      imem_ready = cur.imem_ready; dmem_ready = cur.dmem_ready;
      @(negedge clk);
      act_v = {state, ir_write, pc_write, reg_write, dmem_req, dmem_we, busy, fault};
      exp_v = {cur.st, cur.ir, cur.pc, cur.rw, cur.req, cur.we, cur.busy, cur.flt};
`ifdef PERF_COUNTERS_EN
      exp_cyc = cur.cyc;
      exp_ret = cur.ret;
`else
      exp_cyc = '0;
      exp_ret = '0;
`endif
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs @%0t: {state,ir,pc,rw,req,we,busy,fault} got %b expected %b",
                 $time, act_v, exp_v);
      end
      checks++;
      if (cycle_count !== exp_cyc || instret !== exp_ret) begin
        errors++;
        $display("FAIL counters @%0t: cycle_count=%0d instret=%0d expected %0d %0d",
                 $time, cycle_count, instret, exp_cyc, exp_ret);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
